wsp_tap_ctrl: RTL

Wrapper serial port controller for the IEEE 1500 wrapper. It runs a 16-state IEEE 1149.1-style TAP state machine clocked by WRCK and steered by a TMS input. From that machine it generates the wrapper serial control signals consumed by the WIR stage: SelectWIR, CaptureWR, ShiftWR, UpdateWR and the synchronous resetn. It also retimes the selected serial output (WIR or data-register chain) onto WSO.

---
 rtl/wsp_tap_ctrl_if.sv | 28 ++
 rtl/wsp_tap_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/wsp_tap_ctrl_if.sv
// Wrapper serial port signal bundle: TAP steering inputs, serial chain returns,
// and the decoded wrapper control / retimed serial outputs.
interface wsp_tap_ctrl_if;
    logic        tms;
    logic        wir_so;
    logic        wdr_so;
    logic        SelectWIR;
    logic        CaptureWR;
    logic        ShiftWR;
    logic        UpdateWR;
    logic        resetn;
    logic        wso;
    logic        wso_en;
    logic [3:0]  tap_state;
    logic [15:0] shift_count;

    modport slave (
        input  tms, wir_so, wdr_so,
        output SelectWIR, CaptureWR, ShiftWR, UpdateWR, resetn,
               wso, wso_en, tap_state, shift_count
    );

    modport master (
        output tms, wir_so, wdr_so,
        input  SelectWIR, CaptureWR, ShiftWR, UpdateWR, resetn,
               wso, wso_en, tap_state, shift_count
    );
endinterface

// File: rtl/wsp_tap_ctrl.sv
// IEEE 1500 wrapper serial port controller: 1149.1-style TAP FSM on WRCK,
// Moore-decoded WIR controls, retimed WSO and a saturating shift counter.
//
// state | meaning
// TLR   F | test-logic-reset, resetn low      RTI   C | run-test/idle
// SELDR 7 | select DR column                  SELIR 4 | select IR column
// CAPDR 6 | capture DR                        CAPIR E | capture IR
// SHDR  2 | shift DR                          SHIR  A | shift IR
// EX1DR 1 | exit1 DR                          EX1IR 9 | exit1 IR
// PAUDR 3 | pause DR                          PAUIR B | pause IR
// EX2DR 0 | exit2 DR                          EX2IR 8 | exit2 IR
// UPDDR 5 | update DR                         UPDIR D | update IR
module wsp_tap_ctrl (
    input  logic            WRCK,
    input  logic            WRSTN,
    wsp_tap_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        TLR   = 4'hF, RTI   = 4'hC,
        SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
        PAUDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
        SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
        PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
    } state_e;

    state_e      state_q, state_d;
    logic        wso_q, wso_d;
    logic        wso_en_q, wso_en_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sel_wir, in_cap, in_shift, in_upd;

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_q  <= TLR;
            wso_q    <= 1'b0;
            wso_en_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            wso_q    <= wso_d;
            wso_en_q <= wso_en_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:   state_d = bus.tms ? TLR   : RTI;
            RTI:   state_d = bus.tms ? SELDR : RTI;
            SELDR: state_d = bus.tms ? SELIR : CAPDR;
            CAPDR: state_d = bus.tms ? EX1DR : SHDR;
            SHDR:  state_d = bus.tms ? EX1DR : SHDR;
            EX1DR: state_d = bus.tms ? UPDDR : PAUDR;
            PAUDR: state_d = bus.tms ? EX2DR : PAUDR;
            EX2DR: state_d = bus.tms ? UPDDR : SHDR;
            UPDDR: state_d = bus.tms ? SELDR : RTI;
            SELIR: state_d = bus.tms ? TLR   : CAPIR;
            CAPIR: state_d = bus.tms ? EX1IR : SHIR;
            SHIR:  state_d = bus.tms ? EX1IR : SHIR;
            EX1IR: state_d = bus.tms ? UPDIR : PAUIR;
            PAUIR: state_d = bus.tms ? EX2IR : PAUIR;
            EX2IR: state_d = bus.tms ? UPDIR : SHIR;
            UPDIR: state_d = bus.tms ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Controls decode only from the state register so tms cannot glitch them.
    always_comb begin
        sel_wir  = state_q inside {SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR};
        in_cap   = state_q inside {CAPDR, CAPIR};
        in_shift = state_q inside {SHDR, SHIR};
        in_upd   = state_q inside {UPDDR, UPDIR};
    end

    always_comb begin
        wso_d    = 1'b0;
        wso_en_d = 1'b0;
        cnt_d    = cnt_q;
        if (in_shift) begin
            wso_en_d = 1'b1;
            wso_d    = sel_wir ? bus.wir_so : bus.wdr_so;
        end
        if (in_cap) begin
            cnt_d = 16'd0;
        end else if (in_shift && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        bus.SelectWIR   = sel_wir;
        bus.CaptureWR   = in_cap;
        bus.ShiftWR     = in_shift;
        bus.UpdateWR    = in_upd;
        bus.resetn      = (state_q != TLR);
        bus.wso         = wso_q;
        bus.wso_en      = wso_en_q;
        bus.tap_state   = state_q;
        bus.shift_count = cnt_q;
    end

endmodule
